// File: rtl/interp_result_packer.sv
// rtl/interp_result_packer.sv - packs interpolation result bytes into addressed ZBT write words (optional RESULT_CHECKSUM_EN adds chk_sum)
module interp_result_packer #(
    parameter int FIFO_AW    = 3,
    parameter int ADDR_W     = 19,
    parameter int LINE_WORDS = 180
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [2:0]        line_state,
    input  logic [7:0]        done_a,
    input  logic [7:0]        done_b,
    input  logic [7:0]        done_c,
    input  logic [7:0]        done_d,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] line_stride,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [31:0]       wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              line_done,
    output logic              overflow,
    output logic              empty
`ifdef RESULT_CHECKSUM_EN
    ,
    output logic [31:0]       chk_sum
`endif
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int WC_W  = $clog2(LINE_WORDS);
    localparam int ENT_W = ADDR_W + 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ABC = 2'd1,
        WAIT_D   = 2'd2,
        PUSH     = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [7:0]        cap_a;
    logic [7:0]        cap_b;
    logic [7:0]        cap_c;
    logic [7:0]        cap_d;

    logic [WC_W-1:0]   word_cnt;
    logic [ADDR_W-1:0] line_addr;
    logic [ADDR_W-1:0] stride;

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [FIFO_AW:0]  wr_ptr;
    logic [FIFO_AW:0]  rd_ptr;
    logic [ENT_W-1:0]  rd_entry;

    logic              group_edge;
    logic              push;
    logic              push_ok;
    logic              pop;
    logic              full;
    logic              last_word;
    logic [31:0]       push_data;
    logic [ADDR_W-1:0] push_addr;

    // S3 and S7 are the states where bytes a/b/c of a group are valid
    assign group_edge = run && ((line_state == 3'd3) || (line_state == 3'd7));

    assign push      = (state == PUSH);
    assign push_data = {cap_d, cap_c, cap_b, cap_a};
    assign push_addr = line_addr + ADDR_W'(word_cnt);
    assign last_word = (word_cnt == WC_W'(LINE_WORDS - 1));

    // FIFO status: extra pointer bit separates full from empty
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop      = !empty && wr_ready;
    assign push_ok  = push && (!full || pop);

    // first-word-fall-through read port, zeroed while nothing is queued
    assign rd_entry  = mem[rd_ptr[FIFO_AW-1:0]];
    assign wr_valid  = !empty;
    assign wr_data   = empty ? 32'd0 : rd_entry[31:0];
    assign wr_addr   = empty ? '0 : rd_entry[ENT_W-1:32];

    // a line ends on the push attempt of its last word, dropped or not
    assign line_done = push && last_word;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic; frame_start restarts group capture from any state
    always_comb begin
        state_next = state;
        if (frame_start) begin
            state_next = WAIT_ABC;
        end else begin
            case (state)
                IDLE:     state_next = IDLE;
                WAIT_ABC: if (group_edge) state_next = WAIT_D;
                WAIT_D:   state_next = run ? PUSH : WAIT_ABC;
                PUSH:     state_next = WAIT_ABC;
                default:  state_next = IDLE;
            endcase
        end
    end

    // byte capture: a/b/c at the group edge, d (registered clip) one cycle later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_a <= 8'd0;
            cap_b <= 8'd0;
            cap_c <= 8'd0;
            cap_d <= 8'd0;
        end else begin
            if (state == WAIT_ABC && group_edge) begin
                cap_a <= done_a;
                cap_b <= done_b;
                cap_c <= done_c;
            end
            if (state == WAIT_D && run) begin
                cap_d <= done_d;
            end
        end
    end

    // address generation advances on every push attempt so later words stay correctly placed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt  <= '0;
            line_addr <= '0;
            stride    <= '0;
        end else if (frame_start) begin
            word_cnt  <= '0;
            line_addr <= base_addr;
            stride    <= line_stride;
        end else if (push) begin
            if (last_word) begin
                word_cnt  <= '0;
                line_addr <= line_addr + stride;
            end else begin
                word_cnt  <= word_cnt + 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because pointers gate visibility
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= {push_addr, push_data};
        end
    end

    // FIFO pointers; frame_start leaves queued words in place
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // sticky drop flag; frame_start clear wins over a same-cycle drop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (frame_start) begin
            overflow <= 1'b0;
        end else if (push && !push_ok) begin
            overflow <= 1'b1;
        end
    end

`ifdef RESULT_CHECKSUM_EN
    // running modulo-2^32 sum of words actually accepted into the FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_sum <= 32'd0;
        end else if (frame_start) begin
            chk_sum <= 32'd0;
        end else if (push_ok) begin
            chk_sum <= chk_sum + push_data;
        end
    end
`endif

endmodule
